// File: rtl/dmux_pkg.sv
// ---------------------------------------------------------------------------
// dmux_pkg
//   Shared definitions for the four-channel dispatcher:
//     - state_e     : dispatcher FSM encoding (EMPTY = 0, FULL = 1)
//     - NUM_CHAN    : number of downstream channels (4)
//     - chan_idx_t  : channel index type (2 bits, wraps naturally mod 4)
//     - rr_pick()   : round-robin scan helper used by the dispatcher
// ---------------------------------------------------------------------------
package dmux_pkg;

  localparam int unsigned NUM_CHAN   = 4;
  localparam int unsigned CHAN_IDX_W = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef logic [CHAN_IDX_W-1:0] chan_idx_t;

  // First enabled channel when scanning ptr, ptr+1, ... (mod NUM_CHAN).
  // When no channel is enabled the result is ptr; callers must not act on
  // it in that case (the dispatcher blocks acceptance then).
  function automatic chan_idx_t rr_pick(input logic [NUM_CHAN-1:0] en,
                                        input chan_idx_t           ptr);
    chan_idx_t pick;
    chan_idx_t cand;
    logic      found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      cand = ptr + chan_idx_t'(i);
      if (!found && en[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dmux1to4.sv
// ---------------------------------------------------------------------------
// dmux1to4
//   Plain 1-to-4 demultiplexer: routes `in` to exactly the output selected
//   by {sel1, sel0}; all other outputs are low.
//   Ports:
//     in          data/strobe to route
//     sel0, sel1  select index (sel1 = MSB)
//     y0..y3      routed outputs
// ---------------------------------------------------------------------------
module dmux1to4 (
  input  logic in,
  input  logic sel0,
  input  logic sel1,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  assign y0 = in & ~sel1 & ~sel0;
  assign y1 = in & ~sel1 &  sel0;
  assign y2 = in &  sel1 & ~sel0;
  assign y3 = in &  sel1 &  sel0;

endmodule

// File: rtl/dmux_dispatch4.sv
// ---------------------------------------------------------------------------
// dmux_dispatch4
//   Single-entry dispatcher: accepts a word from upstream into a holding
//   register and offers it to one of four downstream channels, chosen
//   round-robin among the channels whose chan_enN is high.
//
//   Handshakes (both sides): a transfer happens in a cycle where valid and
//   ready are both high. The dispatcher never withdraws out_validN or
//   changes out_data/target once offered, until that channel's out_readyN
//   completes the transfer. in_ready may depend combinationally on
//   out_readyN (pass-through of downstream acceptance allows 1 word/cycle).
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     in_data/in_valid/in_ready  upstream word interface
//     chan_en0..3                channel eligible for new assignments
//     out_data                   held word, broadcast to all channels
//     out_valid0..3              held word offered to channel N
//     out_ready0..3              channel N accepts
//     sel0, sel1                 registered target channel (sel1 = MSB)
//     busy                       holding register occupied; this is also
//                                the FSM state (FULL) made observable
// ---------------------------------------------------------------------------
module dmux_dispatch4
  import dmux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             chan_en0,
  input  logic             chan_en1,
  input  logic             chan_en2,
  input  logic             chan_en3,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic             out_valid3,
  input  logic             out_ready0,
  input  logic             out_ready1,
  input  logic             out_ready2,
  input  logic             out_ready3,
  output logic             sel0,
  output logic             sel1,
  output logic             busy
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  chan_idx_t        ptr_q,   ptr_d;
  chan_idx_t        tgt_q,   tgt_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // -------------------------------------------------------------------------
  // Channel vectors
  // -------------------------------------------------------------------------
  logic [NUM_CHAN-1:0] en_vec;
  logic [NUM_CHAN-1:0] rdy_vec;

  assign en_vec  = {chan_en3, chan_en2, chan_en1, chan_en0};
  assign rdy_vec = {out_ready3, out_ready2, out_ready1, out_ready0};

  // -------------------------------------------------------------------------
  // Handshake terms
  // -------------------------------------------------------------------------
  logic      full;
  logic      offer;
  logic      any_en;
  logic      out_hs;
  logic      in_hs;
  chan_idx_t pick;

  assign full   = (state_q == ST_FULL);
  // Offer is masked by reset so nothing is presented while reset is high,
  // even though the registers only clear on the next edge.
  assign offer  = full & ~reset;
  assign any_en = |en_vec;
  // Only the registered target's ready matters; others are ignored.
  assign out_hs = offer & rdy_vec[tgt_q];
  assign in_ready = ~reset & any_en & (~full | out_hs);
  assign in_hs  = in_valid & in_ready;
  assign pick   = rr_pick(en_vec, ptr_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tgt_d   = tgt_q;
    data_d  = data_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_hs) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // in_hs while FULL implies out_hs, so the slot is refilled in the
        // same cycle the old word leaves.
        if (in_hs) begin
          state_d = ST_FULL;
        end else if (out_hs) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Target and pointer only move on acceptance; a dropped chan_en never
    // re-routes a word already held.
    if (in_hs) begin
      tgt_d  = pick;
      ptr_d  = pick + chan_idx_t'(1);
      data_d = in_data;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      tgt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tgt_q   <= tgt_d;
      data_q  <= data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_data = data_q;
  assign sel0     = tgt_q[0];
  assign sel1     = tgt_q[1];
  assign busy     = full;

  dmux1to4 u_valid_dmux (
    .in   (offer),
    .sel0 (tgt_q[0]),
    .sel1 (tgt_q[1]),
    .y0   (out_valid0),
    .y1   (out_valid1),
    .y2   (out_valid2),
    .y3   (out_valid3)
  );

endmodule

// File: tb/tb_dmux_dispatch4.sv
// ---------------------------------------------------------------------------
// tb_dmux_dispatch4
//   Self-checking bench for dmux_dispatch4: a vector table for the reset,
//   round-robin and skip cases, hand-written sequences for backpressure,
//   all-disabled and mid-operation reset, and a scoreboard queue holding
//   {channel, data} of every accepted word until it is delivered.
// ---------------------------------------------------------------------------
module tb_dmux_dispatch4;

  localparam int WIDTH = 8;
  localparam int SB_W  = WIDTH + 2;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       en;
  logic [3:0]       rdy;
  logic [3:0]       ov;
  logic [WIDTH-1:0] out_data;
  logic             sel0, sel1, busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmux_dispatch4 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .chan_en0   (en[0]),
    .chan_en1   (en[1]),
    .chan_en2   (en[2]),
    .chan_en3   (en[3]),
    .out_data   (out_data),
    .out_valid0 (ov[0]),
    .out_valid1 (ov[1]),
    .out_valid2 (ov[2]),
    .out_valid3 (ov[3]),
    .out_ready0 (rdy[0]),
    .out_ready1 (rdy[1]),
    .out_ready2 (rdy[2]),
    .out_ready3 (rdy[3]),
    .sel0       (sel0),
    .sel1       (sel1),
    .busy       (busy)
  );

  // -------------------------------------------------------------------------
  // Scoreboard and reference model
  // -------------------------------------------------------------------------
  logic [SB_W-1:0]  exp_q[$];
  int               checks   = 0;
  int               failures = 0;

  logic             m_full;
  logic [1:0]       m_ptr;
  logic [1:0]       m_tgt;
  logic [WIDTH-1:0] m_data;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs
  // against the model mid-cycle, track deliveries, then advance the model.
  task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] d,
                       input logic [3:0] e, input logic [3:0] rd);
    logic            ohs;
    logic            exp_rdy;
    logic [3:0]      exp_ov;
    logic [1:0]      pick;
    logic [1:0]      kk;
    logic [SB_W-1:0] item;
    @(negedge clk);
    reset    = r;
    in_valid = v;
    in_data  = d;
    en       = e;
    rdy      = rd;
    #1;
    ohs     = m_full & ~r & rd[m_tgt];
    exp_rdy = ~r & (|e) & (~m_full | ohs);
    exp_ov  = (m_full && !r) ? (4'b0001 << m_tgt) : 4'b0000;
    check("in_ready",  in_ready,     exp_rdy);
    check("out_valid", ov,           exp_ov);
    check("sel",       {sel1, sel0}, m_tgt);
    check("busy",      busy,         m_full);
    check("out_data",  out_data,     m_data);
    for (int k = 0; k < 4; k++) begin
      if (ov[k] && rd[k]) begin
        kk = k[1:0];
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery: got ch%0d data %0h expected none",
                   kk, out_data);
        end else begin
          item = exp_q.pop_front();
          check("delivery", {kk, out_data}, item);
        end
      end
    end
    if (r) begin
      m_full = 1'b0;
      m_ptr  = 2'd0;
      m_tgt  = 2'd0;
      m_data = '0;
      exp_q.delete();
    end else if (v && exp_rdy) begin
      pick = m_ptr;
      repeat (3) if (!e[pick]) pick = pick + 2'd1;
      exp_q.push_back({pick, d});
      m_tgt  = pick;
      m_data = d;
      m_ptr  = pick + 2'd1;
      m_full = 1'b1;
    end else if (ohs) begin
      m_full = 1'b0;
    end
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic             rst;
    logic             vld;
    logic [WIDTH-1:0] d;
    logic [3:0]       en;
    logic [3:0]       rdy;
    logic             e_rdy;
    logic [3:0]       e_ov;
    logic [1:0]       e_sel;
    logic             e_busy;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl[NV];

  // -------------------------------------------------------------------------
  // Test
  // -------------------------------------------------------------------------
  initial begin
    //            rst  vld  d      en    rdy   rdy  ov    sel   busy
    // reset with in_valid high
    tbl[0]  = '{1'b1, 1'b1, 8'h00, 4'hF, 4'hF, 1'b0, 4'h0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h00, 4'hF, 4'hF, 1'b0, 4'h0, 2'd0, 1'b0};
    // round-robin stream 0x11..0x55 -> ch0,1,2,3,0
    tbl[2]  = '{1'b0, 1'b1, 8'h11, 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h22, 4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'h33, 4'hF, 4'hF, 1'b1, 4'h2, 2'd1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h44, 4'hF, 4'hF, 1'b1, 4'h4, 2'd2, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'h55, 4'hF, 4'hF, 1'b1, 4'h8, 2'd3, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0};
    // reset, then skip disabled channels: en = 0101 -> ch0,2,0
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 4'hF, 4'hF, 1'b0, 4'h0, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'hA1, 4'h5, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'hA2, 4'h5, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 8'hA3, 4'h5, 4'hF, 1'b1, 4'h4, 2'd2, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 4'h5, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 4'h5, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    en       = 4'hF;
    rdy      = 4'hF;
    @(posedge clk);
    m_full = 1'b0;
    m_ptr  = 2'd0;
    m_tgt  = 2'd0;
    m_data = '0;

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].rst, tbl[i].vld, tbl[i].d, tbl[i].en, tbl[i].rdy);
      check($sformatf("tbl%0d_in_ready", i),  in_ready,     tbl[i].e_rdy);
      check($sformatf("tbl%0d_out_valid", i), ov,           tbl[i].e_ov);
      check($sformatf("tbl%0d_sel", i),       {sel1, sel0}, tbl[i].e_sel);
      check($sformatf("tbl%0d_busy", i),      busy,         tbl[i].e_busy);
    end

    // Backpressure: 0xA5 to ch1 (ptr = 1), ch1 stalls 4 cycles while its
    // enable also drops; non-target readies stay high and are ignored.
    cycle(1'b0, 1'b1, 8'hA5, 4'hF, 4'hF);
    repeat (4) begin
      cycle(1'b0, 1'b1, 8'h5A, 4'b1101, 4'b1101);
      check("bp_out_valid1", ov,       4'b0010);
      check("bp_out_data",   out_data, 8'hA5);
      check("bp_in_ready",   in_ready, 1'b0);
    end
    cycle(1'b0, 1'b1, 8'h5A, 4'hF, 4'hF);
    check("bp_release_in_ready", in_ready, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 4'hF, 4'hF);
    check("bp_next_target", ov, 4'b0100);

    // All enables low: nothing accepted, pointer (3) must survive.
    repeat (3) begin
      cycle(1'b0, 1'b1, 8'h66, 4'h0, 4'hF);
      check("noen_in_ready", in_ready, 1'b0);
    end
    cycle(1'b0, 1'b1, 8'h67, 4'hF, 4'hF);
    cycle(1'b0, 1'b0, 8'h00, 4'hF, 4'hF);
    check("noen_ptr_kept", {sel1, sel0}, 2'd3);
    cycle(1'b0, 1'b1, 8'h68, 4'b0100, 4'hF);
    cycle(1'b0, 1'b0, 8'h00, 4'hF, 4'hF);
    check("reen_ch2", ov, 4'b0100);
    check("reen_data", out_data, 8'h68);

    // Reset mid-operation with 0x3C held for ch3.
    cycle(1'b0, 1'b1, 8'h3C, 4'b1000, 4'hF);
    cycle(1'b0, 1'b0, 8'h00, 4'hF, 4'h0);
    check("mid_held", ov, 4'b1000);
    cycle(1'b1, 1'b0, 8'h00, 4'hF, 4'hF);
    check("mid_reset_ov3", ov[3], 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 4'hF, 4'hF);
    check("post_reset_ov", ov,   4'b0000);
    check("post_reset_busy", busy, 1'b0);
    cycle(1'b0, 1'b1, 8'h77, 4'hF, 4'hF);
    cycle(1'b0, 1'b0, 8'h00, 4'hF, 4'hF);
    check("post_reset_ch0", ov, 4'b0001);
    check("post_reset_data", out_data, 8'h77);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
